// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Launch with a one-cycle start pulse in IDLE; busy stays high until the
// one-cycle done pulse, which carries the registered result.
// Optional feature macro: DIV_EARLY_OUT_EN. When defined, divide-by-zero
// and signed overflow skip the iteration (IDLE -> DONE). When undefined,
// every operation takes the full CALC/FIX path (constant time).
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [3:0]       div_ctrl,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] divisor_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             rem_op_q;
    logic             special_q;
    logic [WIDTH-1:0] special_res_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;

    // Launch-time decode of the raw operands.
    logic             valid_op;
    logic             is_signed;
    logic             is_rem;
    logic             sign1;
    logic             sign2;
    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;
    logic             special;
    logic [WIDTH-1:0] special_res;

    // Iteration and sign-fix next values.
    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] fix_res_d;

    // Decode the requested op, operand magnitudes and RISC-V special cases.
    always_comb begin
        valid_op    = (div_ctrl[3:2] == 2'b11);
        is_signed   = ~div_ctrl[0];
        is_rem      = div_ctrl[1];
        sign1       = is_signed & op1[WIDTH-1];
        sign2       = is_signed & op2[WIDTH-1];
        abs1        = sign1 ? (~op1 + 1'b1) : op1;
        abs2        = sign2 ? (~op2 + 1'b1) : op2;
        special     = 1'b0;
        special_res = '0;
        if (op2 == '0) begin
            special     = 1'b1;
            special_res = is_rem ? op1 : '1;
        end else if (is_signed && (op1 == MIN_NEG) && (op2 == '1)) begin
            special     = 1'b1;
            special_res = is_rem ? '0 : MIN_NEG;
        end
    end

    // One restoring step and the final sign correction / result select.
    always_comb begin
        // The remainder is always below the divisor, so the difference fits
        // in WIDTH bits and the carry-out can be dropped.
        trial     = {rem_q, quo_q[WIDTH-1]};
        ge        = (trial >= {1'b0, divisor_q});
        rem_d     = ge ? (trial[WIDTH-1:0] - divisor_q) : trial[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], ge};
        fix_res_d = '0;
        if (special_q) begin
            fix_res_d = special_res_q;
        end else if (rem_op_q) begin
            fix_res_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        end else begin
            fix_res_d = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        end
    end

    // Control FSM with registered busy/done/result; flush aborts silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            divisor_q     <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            rem_op_q      <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && valid_op && !flush) begin
                        rem_q         <= '0;
                        quo_q         <= abs1;
                        divisor_q     <= abs2;
                        neg_quo_q     <= sign1 ^ sign2;
                        neg_rem_q     <= sign1;
                        rem_op_q      <= is_rem;
                        special_q     <= special;
                        special_res_q <= special_res;
                        cnt_q         <= '0;
                        busy_q        <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
                        if (special) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            state_q <= S_CALC;
                        end
`else
                        state_q <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        result_q <= fix_res_d;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and random bench for div_unit with an expected-result queue.
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [3:0]  div_ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    logic [31:0] exp_q[$];
    int          checks;
    int          failures;
    logic [31:0] last_res;

    localparam logic [3:0] DIV  = 4'b1100;
    localparam logic [3:0] DIVU = 4'b1101;
    localparam logic [3:0] REM  = 4'b1110;
    localparam logic [3:0] REMU = 4'b1111;

`ifdef DIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 34;
`endif
    localparam int NORMAL_LAT = 34;

    div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .flush    (flush),
        .div_ctrl (div_ctrl),
        .op1      (op1),
        .op2      (op2),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour, RISC-V semantics.
    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        logic sgn;
        logic rm;
        logic [31:0] r;
        sgn = ~c[0];
        rm  = c[1];
        if (b == 32'd0) begin
            r = rm ? a : 32'hFFFF_FFFF;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = rm ? 32'd0 : 32'h8000_0000;
        end else if (sgn) begin
            if (rm) r = 32'($signed(a) % $signed(b));
            else    r = 32'($signed(a) / $signed(b));
        end else begin
            if (rm) r = a % b;
            else    r = a / b;
        end
        return r;
    endfunction

    function automatic int latency(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return SPECIAL_LAT;
        if (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return SPECIAL_LAT;
        return NORMAL_LAT;
    endfunction

    // Drive a one-cycle start at the current negedge; returns at cycle N+1.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
        div_ctrl = c;
        op1      = a;
        op2      = b;
        start    = 1'b1;
        if (push) exp_q.push_back(model(c, a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at cycle N+k0; waits for done, checks its cycle and the result.
    task automatic wait_done(input string tag, input int lat, input int k0);
        int k;
        logic [31:0] e;
        k = k0;
        if (k0 == 1) check({tag, "_busy_n1"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && k < lat + 10) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_cycle"}, 32'(k), 32'(lat));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
            e = 'x;
        end else begin
            e = exp_q.pop_front();
            check({tag, "_result"}, result, e);
            last_res = e;
        end
        @(negedge clk);
        check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b);
        issue(c, a, b, 1'b1);
        wait_done(tag, latency(c, a, b), 1);
    endtask

    initial begin
        int   seen_done;
        int   r;
        logic [3:0] rc;
        logic [31:0] ra;
        logic [31:0] rb;
        checks   = 0;
        failures = 0;
        last_res = 32'd0;
        rst_n    = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        div_ctrl = 4'd0;
        op1      = 32'd0;
        op2      = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {30'd0, busy, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed arithmetic
        run_op("divu_100_7", DIVU, 32'd100, 32'd7);
        run_op("remu_100_7", REMU, 32'd100, 32'd7);
        run_op("div_m7_2",   DIV,  32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2",   REM,  32'hFFFF_FFF9, 32'd2);
        run_op("div_ovf",    DIV,  32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf",    REM,  32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_5_0",   DIVU, 32'd5, 32'd0);
        run_op("remu_5_0",   REMU, 32'd5, 32'd0);
        run_op("div_m9_0",   DIV,  32'hFFFF_FFF7, 32'd0);
        run_op("divu_big",   DIVU, 32'hFFFF_FFFF, 32'h8000_0001);
        run_op("rem_7_m3",   REM,  32'd7, 32'hFFFF_FFFD);

        // Invalid div_ctrl is ignored
        issue(4'b0101, 32'd9, 32'd3, 1'b0);
        check("invalid_ctrl_busy", 32'(busy), 32'd0);

        // flush and start together in IDLE: flush wins
        flush = 1'b1;
        issue(DIVU, 32'd9, 32'd3, 1'b0);
        flush = 1'b0;
        check("flush_start_idle", 32'(busy), 32'd0);

        // Flush mid-CALC, then a new start at N+20 completes at N+54
        issue(DIVU, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_n11", {30'd0, busy, done}, 32'd0);
        seen_done = 0;
        repeat (9) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        check("flush_no_done", 32'(seen_done), 32'd0);
        check("flush_result_kept", result, last_res);
        issue(DIVU, 32'd12345, 32'd10, 1'b1);
        wait_done("after_flush", NORMAL_LAT, 1);

        // Reset mid-CALC
        issue(REMU, 32'd77, 32'd5, 1'b0);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midcalc_reset_flags", {30'd0, busy, done}, 32'd0);
        check("midcalc_reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Start pulses while busy are ignored: exactly one done
        issue(DIV, 32'hFFFF_FF00, 32'd16, 1'b1);
        repeat (4) @(negedge clk);
        issue(DIVU, 32'd50, 32'd5, 1'b0);
        repeat (14) @(negedge clk);
        issue(REMU, 32'd50, 32'd0, 1'b0);
        wait_done("busy_start", NORMAL_LAT, 21);
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        check("busy_start_single_done", 32'(seen_done), 32'd0);

        // Random operations
        for (int i = 0; i < 8; i++) begin
            r  = $urandom_range(0, 3);
            rc = {2'b11, r[1:0]};
            ra = $urandom;
            r  = $urandom_range(0, 3);
            if (r == 0)      rb = 32'($urandom_range(1, 15));
            else if (r == 1) rb = 32'd0;
            else             rb = $urandom;
            run_op("random", rc, ra, rb);
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin
        #400000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 divider for the execute stage. It handles the DIV, DIVU, REM and REMU operations, so the combinational divide paths in the ALU can be retired. The execute stage launches an operation with a one-cycle `start` pulse and stalls the pipeline while `busy` is high. The unit returns a 32-bit result with a one-cycle `done` pulse, and that result is muxed onto the ALU result bus. Operation codes reuse the ALU control encoding, so the decoder needs no change.

## Interface
- `WIDTH`, default 32: operand and result width; RV32 builds use only 32.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `start` input, 1 bit: launches an operation; sampled only in IDLE.
- `flush` input, 1 bit: aborts the operation in flight (branch mispredict or trap).
- `div_ctrl` input, 4 bits: 4'b1100 DIV, 4'b1101 DIVU, 4'b1110 REM, 4'b1111 REMU.
- `op1` input, WIDTH bits: dividend.
- `op2` input, WIDTH bits: divisor.
- `busy` output, 1 bit: operation in progress; the pipeline stalls while high.
- `done` output, 1 bit: one-cycle pulse; `result` is valid in the same cycle.
- `result` output, WIDTH bits: quotient or remainder.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE**
  - `start`=1 with a valid `div_ctrl` (top bits 2'b11) captures `op1`, `op2` and the op.
  - Signed ops (DIV, REM) take the absolute value of each operand and record the quotient sign (sign1 XOR sign2) and the remainder sign (sign1).
  - Next state is CALC, and the iteration counter loads 0.
  - `start` with any other `div_ctrl` is ignored.
- **CALC**
  - One restoring step per cycle: shift {rem, quo} left by one; if rem ≥ divisor, subtract the divisor and set the quotient LSB.
  - After WIDTH steps (counter = WIDTH−1), go to FIX.
- **FIX**
  - Apply sign correction: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Select the quotient for DIV/DIVU or the remainder for REM/REMU into the `result` register.
  - Next state is DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Special cases (RISC-V semantics, required bit-exact):**
  - Divide by zero: quotient = all ones (0xFFFFFFFF); remainder = `op1` unmodified.
  - Signed overflow (`op1`=0x80000000, `op2`=0xFFFFFFFF, DIV/REM only): quotient = 0x80000000, remainder = 0.
  - Special cases are detected in IDLE from the raw operands; their result bypasses the iteration.
- **Result hold:** `result` holds its last value until the next FIX or special-case load.
- **`flush`:** in any non-IDLE state, go to IDLE next cycle. `done` is never asserted for the flushed operation and `result` is unchanged. If `flush` and `start` are both high in IDLE, `flush` wins and nothing launches.
- **`start` while busy:** ignored; there is no queueing.
- **Reset:** `rst_n`=0 puts the unit in IDLE on the next edge from any state, including mid-CALC. `busy`=0, `done`=0, `result`=0, counter=0.

## Timing
- `start` sampled at edge N launches the operation.
- Normal path:
  - CALC spans cycles N+1 to N+32.
  - FIX is cycle N+33.
  - DONE is cycle N+34: `done`=1 and `result` is valid.
- `busy`=1 from N+1 through N+34 inclusive, so it is high in the `done` cycle and low the cycle after.
- A new `start` is accepted at the earliest in cycle N+35, the first IDLE cycle.
- Outputs are registered; there is no combinational path from inputs to `busy`, `done` or `result`.
- The early-out latency is given under Configuration.

## Configuration
- Macro: `DIV_EARLY_OUT_EN`.
- **Defined:** special cases (divide by zero, signed overflow) go IDLE → DONE. `done` and `result` are valid at N+1, with `busy`=1 only in N+1.
- **Undefined:** special cases run the full CALC/FIX sequence with the result forced in FIX, so latency is N+34, identical to the normal path. This gives constant-time division.
- Result values are identical in both builds.

## Test plan
- DIVU `op1`=100, `op2`=7, `start` at N → `done` at N+34 with `result`=14; REMU with the same operands → 2.
- DIV `op1`=−7 (0xFFFFFFF9), `op2`=2 → 0xFFFFFFFD (−3); REM with the same operands → 0xFFFFFFFF (−1).
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5. `done` at N+1 with `DIV_EARLY_OUT_EN` defined, at N+34 without.
- `flush` at N+10 of a DIVU → IDLE at N+11, no `done`, `result` keeps its previous value. A second `start` at N+20 issued during the flushed operation's lifetime is accepted, since the unit is already IDLE, and completes at N+54.
- `rst_n`=0 at N+15 mid-CALC → next cycle `busy`=0, `done`=0, `result`=0. `start` pulses during `busy` are ignored, with exactly one `done` per accepted `start`.
